// File: rtl/seven_seg_pkg.sv
// Shared types, glyph table and decode helper for the seven-segment receiver.
`default_nettype none

package seven_seg_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [6:0] seg_t;

  // Active-low glyphs, bit order gfedcba
  localparam seg_t GLYPH_0 = 7'b1000000;
  localparam seg_t GLYPH_1 = 7'b1111001;
  localparam seg_t GLYPH_2 = 7'b0100100;
  localparam seg_t GLYPH_3 = 7'b0110000;
  localparam seg_t GLYPH_4 = 7'b0011001;
  localparam seg_t GLYPH_5 = 7'b0010010;
  localparam seg_t GLYPH_6 = 7'b0000010;
  localparam seg_t GLYPH_7 = 7'b1111000;
  localparam seg_t GLYPH_8 = 7'b0000000;
  localparam seg_t GLYPH_9 = 7'b0010000;
  localparam seg_t GLYPH_A = 7'b0001000;
  localparam seg_t GLYPH_B = 7'b0000011;
  localparam seg_t GLYPH_C = 7'b1000110;
  localparam seg_t GLYPH_D = 7'b0100001;
  localparam seg_t GLYPH_E = 7'b0000110;
  localparam seg_t GLYPH_F = 7'b0001110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } rx_state_t;

  // Returns {legal, nibble}; illegal patterns return all zeros.
  function automatic logic [4:0] seg_to_nibble(seg_t seg);
    logic [4:0] res;
    case (seg)
      GLYPH_0: res = 5'h10;
      GLYPH_1: res = 5'h11;
      GLYPH_2: res = 5'h12;
      GLYPH_3: res = 5'h13;
      GLYPH_4: res = 5'h14;
      GLYPH_5: res = 5'h15;
      GLYPH_6: res = 5'h16;
      GLYPH_7: res = 5'h17;
      GLYPH_8: res = 5'h18;
      GLYPH_9: res = 5'h19;
      GLYPH_A: res = 5'h1A;
      GLYPH_B: res = 5'h1B;
      GLYPH_C: res = 5'h1C;
      GLYPH_D: res = 5'h1D;
      GLYPH_E: res = 5'h1E;
      GLYPH_F: res = 5'h1F;
      default: res = 5'h00;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seven_seg_glyph_decode.sv
// Combinational glyph decoder: active-low segment pattern to hex nibble.
`default_nettype none

module seven_seg_glyph_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] segment,
  output logic [3:0] nibble,
  output logic       legal
);

  logic [4:0] dec;

  assign dec    = seg_to_nibble(segment);
  assign legal  = dec[4];
  assign nibble = dec[3:0];

endmodule

`default_nettype wire

// File: rtl/seven_segment_rx.sv
// Seven-segment bus receiver: debounces each digit dwell, decodes it and
// assembles a 32-bit frame once all eight digits have been captured.
`default_nettype none

module seven_segment_rx
  import seven_seg_pkg::*;
#(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_en,
  input  logic [6:0]  segment,
  input  logic [7:0]  anode,
  output logic [31:0] value,
  output logic        value_valid,
  output logic        frame_valid,
  output logic        err_pattern,
  output logic        err_anode
);

  localparam logic [3:0] STABLE_CNT = 4'(STABLE_SAMPLES);

  rx_state_t   state;
  logic [3:0]  cnt;
  logic [7:0]  prev_anode;
  seg_t        prev_segment;
  logic [7:0]  mask;
  logic [31:0] digit_buf;

  logic [7:0]  sel;
  logic        blank;
  logic        multi;
  logic        same;
  logic        new_dwell;
  logic        settle_done;
  logic        do_capture;
  logic [2:0]  idx;
  logic [3:0]  nibble;
  logic        legal;
  logic [7:0]  mask_next;
  logic [31:0] buf_next;

  seven_seg_glyph_decode u_decode (
    .segment (segment),
    .nibble  (nibble),
    .legal   (legal)
  );

  assign sel   = ~anode;
  assign blank = (sel == 8'h00);
  // Clearing the lowest set bit leaves something only if two or more were set
  assign multi = ((sel & (sel - 8'd1)) != 8'h00);
  assign same  = (anode == prev_anode) && (segment == prev_segment);

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel[i]) idx = 3'(i);
    end
  end

  assign new_dwell   = !same || (state == IDLE);
  assign settle_done = (state == SETTLE) && same && ((cnt + 4'd1) == STABLE_CNT);
  assign do_capture  = !blank && !multi &&
                       ((new_dwell && (STABLE_CNT == 4'd1)) || (!new_dwell && settle_done));

  assign mask_next = mask | (8'h01 << idx);

  always_comb begin
    buf_next = digit_buf;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 3'(i)) buf_next[4*i +: 4] = nibble;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      prev_anode   <= 8'hFF;
      prev_segment <= 7'h7F;
      mask         <= 8'h00;
      digit_buf    <= 32'h0;
      value        <= 32'h0;
      value_valid  <= 1'b0;
      frame_valid  <= 1'b0;
      err_pattern  <= 1'b0;
      err_anode    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      err_pattern <= 1'b0;
      err_anode   <= 1'b0;
      if (sample_en) begin
        prev_anode   <= anode;
        prev_segment <= segment;

        if (blank || multi) begin
          state     <= IDLE;
          cnt       <= 4'd0;
          err_anode <= multi;
        end else if (new_dwell) begin
          cnt   <= 4'd1;
          state <= (STABLE_CNT == 4'd1) ? HELD : SETTLE;
        end else if (state == SETTLE) begin
          cnt <= cnt + 4'd1;
          if (settle_done) state <= HELD;
        end

        if (do_capture) begin
          if (legal) begin
            digit_buf <= buf_next;
            if (mask_next == 8'hFF) begin
              mask        <= 8'h00;
              value       <= buf_next;
              frame_valid <= 1'b1;
              value_valid <= 1'b1;
            end else begin
              mask <= mask_next;
            end
          end else begin
            err_pattern <= 1'b1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_rx.sv
// Directed self-checking bench for seven_segment_rx.
`default_nettype none

module tb_seven_segment_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_en;
  logic [6:0]  segment;
  logic [7:0]  anode;
  logic [31:0] value;
  logic        value_valid;
  logic        frame_valid;
  logic        err_pattern;
  logic        err_anode;

  int n_cmp = 0;
  int n_err = 0;

  seven_segment_rx #(.STABLE_SAMPLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_en   (sample_en),
    .segment     (segment),
    .anode       (anode),
    .value       (value),
    .value_valid (value_valid),
    .frame_valid (frame_valid),
    .err_pattern (err_pattern),
    .err_anode   (err_anode)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Drive one cycle, then settle past the edge before outputs are examined.
  task automatic step(input logic en, input logic [7:0] an, input logic [6:0] seg);
    sample_en = en;
    anode     = an;
    segment   = seg;
    @(posedge clk);
    #1;
  endtask

  task automatic sel_digit(input int d, output logic [7:0] an);
    an = 8'hFF;
    an[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b0, 8'hFF, 7'h7F);
    step(1'b0, 8'hFF, 7'h7F);
    rst = 1'b0;
    step(1'b1, 8'hFF, 7'h7F);
    n_cmp++; if (value !== 32'h0) begin n_err++; $display("FAIL reset_value got=%h exp=%h", value, 32'h0); end
    n_cmp++; if (value_valid !== 1'b0) begin n_err++; $display("FAIL reset_value_valid got=%b exp=0", value_valid); end
    n_cmp++; if ({frame_valid, err_pattern, err_anode} !== 3'b000) begin
      n_err++; $display("FAIL reset_pulses got=%b exp=000", {frame_valid, err_pattern, err_anode});
    end
  endtask

  // Scan all eight digits holding each for 6 samples; one frame pulse on the
  // 4th sample of the last digit visited.
  task automatic test_full_scan(input logic [31:0] val, input bit descending, input string name);
    logic [7:0] an;
    int d;
    int frames = 0;
    for (int k = 0; k < 8; k++) begin
      d = descending ? 7 - k : k;
      sel_digit(d, an);
      for (int s = 0; s < 6; s++) begin
        step(1'b1, an, glyph(val[4*d +: 4]));
        if (frame_valid === 1'b1) frames++;
        n_cmp++;
        if (frame_valid !== ((k == 7) && (s == 3))) begin
          n_err++; $display("FAIL %s_frame digit=%0d sample=%0d got=%b exp=%b",
                            name, d, s, frame_valid, ((k == 7) && (s == 3)));
        end
        if (k == 7 && s == 3) begin
          n_cmp++; if (value !== val) begin n_err++; $display("FAIL %s_value got=%h exp=%h", name, value, val); end
        end
      end
    end
    n_cmp++; if (frames != 1) begin n_err++; $display("FAIL %s_frame_count got=%0d exp=1", name, frames); end
    n_cmp++; if (value !== val) begin n_err++; $display("FAIL %s_final_value got=%h exp=%h", name, value, val); end
    n_cmp++; if (value_valid !== 1'b1) begin n_err++; $display("FAIL %s_value_valid got=%b exp=1", name, value_valid); end
  endtask

  // Three samples of digit 3 must not capture; the frame only completes once
  // digit 3 is properly held later.
  task automatic test_glitch();
    logic [7:0] an;
    int order [7] = '{4, 5, 6, 7, 0, 1, 2};
    for (int s = 0; s < 3; s++) step(1'b1, 8'hF7, glyph(4'hA));
    for (int k = 0; k < 7; k++) begin
      sel_digit(order[k], an);
      for (int s = 0; s < 4; s++) begin
        step(1'b1, an, glyph(4'(order[k])));
        n_cmp++; if (frame_valid !== 1'b0) begin
          n_err++; $display("FAIL glitch_early_frame digit=%0d sample=%0d got=%b exp=0", order[k], s, frame_valid);
        end
      end
    end
    n_cmp++; if (dut.mask[3] !== 1'b0) begin n_err++; $display("FAIL glitch_mask3 got=%b exp=0", dut.mask[3]); end
    for (int s = 0; s < 4; s++) step(1'b1, 8'hF7, glyph(4'hA));
    n_cmp++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL glitch_final_frame got=%b exp=1", frame_valid); end
    n_cmp++; if (value !== 32'h7654A210) begin n_err++; $display("FAIL glitch_value got=%h exp=%h", value, 32'h7654A210); end
  endtask

  task automatic test_illegal();
    for (int s = 0; s < 6; s++) begin
      step(1'b1, 8'hFB, 7'h7F);
      n_cmp++; if (err_pattern !== (s == 3)) begin
        n_err++; $display("FAIL illegal_err_pattern sample=%0d got=%b exp=%b", s, err_pattern, (s == 3));
      end
      n_cmp++; if (frame_valid !== 1'b0) begin
        n_err++; $display("FAIL illegal_frame sample=%0d got=%b exp=0", s, frame_valid);
      end
    end
    n_cmp++; if (value !== 32'h7654A210) begin n_err++; $display("FAIL illegal_value got=%h exp=%h", value, 32'h7654A210); end
  endtask

  task automatic test_anode_gap();
    for (int s = 0; s < 2; s++) begin
      step(1'b1, 8'hFC, glyph(4'h1));
      n_cmp++; if (err_anode !== 1'b1) begin n_err++; $display("FAIL anode_err sample=%0d got=%b exp=1", s, err_anode); end
      n_cmp++; if (err_pattern !== 1'b0) begin n_err++; $display("FAIL anode_no_pattern sample=%0d got=%b exp=0", s, err_pattern); end
    end
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 8'hFE, glyph(4'h5));
      n_cmp++; if ({frame_valid, err_pattern, err_anode, value_valid} !== 4'b0001 || value !== 32'h7654A210) begin
        n_err++; $display("FAIL gap_hold cycle=%0d got=%b/%h exp=0001/%h",
                          c, {frame_valid, err_pattern, err_anode, value_valid}, value, 32'h7654A210);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] an;
    for (int d = 0; d < 5; d++) begin
      sel_digit(d, an);
      for (int s = 0; s < 4; s++) step(1'b1, an, glyph(4'h0));
    end
    rst = 1'b1;
    step(1'b1, 8'hFE, glyph(4'h0));
    step(1'b1, 8'hFE, glyph(4'h0));
    rst = 1'b0;
    n_cmp++; if (value !== 32'h0 || value_valid !== 1'b0) begin
      n_err++; $display("FAIL midreset_outputs got=%h/%b exp=%h/0", value, value_valid, 32'h0);
    end
    // Descending order: a stale mask of digits 0..4 would complete early.
    test_full_scan(32'hDEADBEEF, 1'b1, "midreset_scan");
  endtask

  initial begin
    rst = 1'b0;
    sample_en = 1'b0;
    anode = 8'hFF;
    segment = 7'h7F;
    test_reset();
    test_full_scan(32'h1234ABCD, 1'b0, "full_scan");
    test_glitch();
    test_illegal();
    test_anode_gap();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seven_segment_rx.md
# seven_segment_rx

Receiver for the multiplexed seven-segment display bus: samples the active-low `segment`/`anode` lines driven by a display scanner and reconstructs the 8-digit hex value. Each pattern must hold stable before it is decoded back to a nibble, and a full 32-bit frame is published once all eight digits have been captured. It serves as the loopback checker and capture front-end for display-driver verification and on-board self-test.

## Interface
- `STABLE_SAMPLES`, default 4: number of consecutive identical samples required before a capture. Legal range is 1–15.
- `clk`  in  1  the single clock. All state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sample_en`  in  1  sample strobe. The inputs are only evaluated on cycles where this is 1.
- `segment`  in  7  active-low segments, bit 6 = g … bit 0 = a.
- `anode`  in  8  active-low digit enables. Bit i low selects digit i.
- `value`  out  32  last complete frame. Digit i maps to `value[4i+3:4i]`.
- `value_valid`  out  1  sticky. Set by the first completed frame, cleared only by reset.
- `frame_valid`  out  1  one-cycle pulse when `value` updates.
- `err_pattern`  out  1  one-cycle pulse when a stable pattern is not a legal hex glyph.
- `err_anode`  out  1  one-cycle pulse on any sampled `anode` with more than one bit low.

## Operation
- **Decode table** (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - Any other pattern is illegal.
- **Anode classification** per sample:
  - `8'hFF` is blank.
  - Exactly one bit low gives digit index i.
  - More than one bit low pulses `err_anode`.
- **FSM states**: IDLE, SETTLE, HELD. All transitions happen only on `sample_en` cycles.
  - Blank or multi-low anode: go to IDLE, `cnt`=0.
  - Valid anode and (`anode`,`segment`) differs from the previous sample: go to SETTLE, `cnt`=1.
  - Same as previous sample in SETTLE: `cnt`+1.
  - When `cnt` reaches `STABLE_SAMPLES`, perform a capture event and move to HELD.
  - HELD stays in HELD while the inputs are unchanged, so there is exactly one capture per dwell.
  - With `STABLE_SAMPLES`=1, the first sample of a new dwell captures immediately.
- **Capture event**:
  - Legal pattern: write `digit_buf[i]` and set `mask[i]`.
  - Illegal pattern: pulse `err_pattern`; `mask` and `digit_buf` are unchanged.
  - Re-capturing a digit already in `mask` overwrites it.
- **Frame completion**: when a capture makes `mask`=8'hFF:
  - `value` takes `digit_buf` including the nibble just captured.
  - `frame_valid`=1 and `value_valid`=1.
  - `mask` clears to 0 on the same edge.
- **`sample_en`=0**: all state holds and the outputs are pulse-free.
- **Previous-sample registers**: `prev_anode` and `prev_segment` update on every `sample_en` cycle.

## Timing
- Reset values:
  - Outputs: `value`=0, `value_valid`=0, `frame_valid`=0, `err_pattern`=0, `err_anode`=0.
  - Internal: `mask`=0, `digit_buf`=0, `cnt`=0, state=IDLE, `prev_anode`=8'hFF, `prev_segment`=7'h7F.
- `rst` has priority over `sample_en`. Reset mid-frame discards the partial `mask`.
- All outputs are registered.
  - Capture, error and frame pulses appear in the cycle after the clock edge that sampled the qualifying input.
  - Pulses are high for exactly one `clk` cycle.
- Capture latency from the first sample of a dwell is `STABLE_SAMPLES` `sample_en` cycles.
- `cnt` saturates at `STABLE_SAMPLES`; it never wraps.
- An `err_anode` sample ends a dwell. It never pulses `err_pattern`.

## Structure
- **Package `seven_seg_pkg`**:
  - `NUM_DIGITS`=8.
  - `seg_t` (`logic [6:0]`).
  - The 16 glyph localparams.
  - Function `seg_to_nibble(seg_t)`, returning {legal, nibble[3:0]}.
  - State enum `rx_state_t` {IDLE, SETTLE, HELD}.
- **Sub-module `seven_seg_glyph_decode`**: combinational, `segment` → `nibble`, `legal`. It wraps the package function so the table can be reused by the display driver's checker.
- **Top-level**: FSM, stability counter, `digit_buf`/`mask`, anode classifier.

## Test plan
- **Reset**: `rst`=1 for 2 cycles, then `sample_en`=1 with `anode`=8'hFF → `value`=0, `value_valid`=0, no pulses.
- **Full scan**: `STABLE_SAMPLES`=4. Scan 32'h1234ABCD for digits 0..7, holding each for 6 samples.
  - Expect exactly one `frame_valid`, on the 4th sample of digit 7.
  - Expect `value`=32'h1234ABCD and `value_valid`=1.
- **Glitch reject**: digit 3 pattern "A" on `anode`=8'hF7 for 3 samples, then switch to digit 4 → no capture for digit 3, `mask[3]`=0.
- **Illegal glyph**: `segment`=7'h7F on `anode`=8'hFB for 6 samples → one `err_pattern` pulse at sample 4, no `frame_valid`.
- **Anode error plus gap**:
  - `anode`=8'hFC for 2 samples → two `err_anode` pulses.
  - Then hold `sample_en`=0 for 10 cycles → no outputs change.
- **Reset mid-frame**: capture 5 digits, assert `rst`, then perform a full scan of 32'hDEADBEEF.
  - Expect a single `frame_valid` only after all 8 new digits, with `value`=32'hDEADBEEF.
